// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter for the LC3 synchronous-read memory: core (C) has fixed priority over loader (L),
// with a starvation guard for L and bounded L burst locking. Optional counters under LC3_ARB_STATS_EN.
module lc3_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt=1;
  // gnt=1 means the access is performed in that same cycle (no separate ready).
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              o_dbg_state
`ifdef LC3_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_c_grants,
  output logic [15:0]       stat_l_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [3:0] LIM_C   = 4'(STARVE_LIM);
  localparam logic [7:0] BMAX_C  = 8'(BURST_MAX);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic [7:0]  r_burst_cnt;
  logic [7:0]  w_burst_nxt;
  logic        r_yield;
  logic        w_yield_nxt;
  logic        w_c_gnt;
  logic        w_l_gnt;
  logic        w_lock_hold;
  logic        r_c_rvalid;
  logic        r_l_rvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ARB;
      r_starve_cnt <= 4'd0;
      r_burst_cnt  <= 8'd0;
      r_yield      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_yield      <= w_yield_nxt;
    end
  end

  // A locked burst continues only while L keeps both req and lock; otherwise the
  // cycle falls through to normal arbitration so there is no dead cycle.
  always_comb begin
    w_c_gnt     = 1'b0;
    w_l_gnt     = 1'b0;
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_yield_nxt = 1'b0;
    w_lock_hold = (r_state == ST_LOCK) && l_req && l_lock;

    if (w_lock_hold) begin
      w_l_gnt     = 1'b1;
      w_burst_nxt = r_burst_cnt + 8'd1;
      if (w_burst_nxt == BMAX_C) begin
        w_state_nxt = ST_ARB;
        w_yield_nxt = 1'b1;
      end
    end else begin
      w_state_nxt = ST_ARB;
      if (r_yield && c_req) begin
        w_c_gnt = 1'b1;
      end else if ((r_starve_cnt == LIM_C) && l_req) begin
        w_l_gnt = 1'b1;
      end else if (c_req) begin
        w_c_gnt = 1'b1;
      end else if (l_req) begin
        w_l_gnt = 1'b1;
      end
      if (w_l_gnt && l_lock) begin
        w_burst_nxt = 8'd1;
        if (BMAX_C == 8'd1) begin
          w_yield_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_LOCK;
        end
      end
    end

    if (reset) begin
      w_c_gnt = 1'b0;
      w_l_gnt = 1'b0;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!l_req || w_l_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt != LIM_C) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (w_c_gnt) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = c_we;
    end else if (w_l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_we    = l_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
    end else begin
      r_c_rvalid <= w_c_gnt && !c_we;
      r_l_rvalid <= w_l_gnt && !l_we;
    end
  end

  assign c_gnt       = w_c_gnt;
  assign l_gnt       = w_l_gnt;
  assign c_rvalid    = r_c_rvalid;
  assign l_rvalid    = r_l_rvalid;
  assign c_rdata     = r_c_rvalid ? mem_rdata : '0;
  assign l_rdata     = r_l_rvalid ? mem_rdata : '0;
  assign o_dbg_state = (r_state == ST_LOCK);

`ifdef LC3_ARB_STATS_EN
  logic [15:0] r_stat_c_grants;
  logic [15:0] r_stat_l_grants;
  logic [15:0] r_stat_conflicts;

  // Counters wrap naturally; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_c_grants  <= 16'd0;
      r_stat_l_grants  <= 16'd0;
      r_stat_conflicts <= 16'd0;
    end else if (stat_clr) begin
      r_stat_c_grants  <= 16'd0;
      r_stat_l_grants  <= 16'd0;
      r_stat_conflicts <= 16'd0;
    end else begin
      if (w_c_gnt)        r_stat_c_grants  <= r_stat_c_grants + 16'd1;
      if (w_l_gnt)        r_stat_l_grants  <= r_stat_l_grants + 16'd1;
      if (c_req && l_req) r_stat_conflicts <= r_stat_conflicts + 16'd1;
    end
  end

  assign stat_c_grants  = r_stat_c_grants;
  assign stat_l_grants  = r_stat_l_grants;
  assign stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: vector table for single-cycle behaviour plus
// hand sequences for the locked burst, mid-cycle reset and (when enabled) the stats counters.
module tb_lc3_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        c_req, c_we, l_req, l_we, l_lock;
  logic [15:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid, mem_we, o_dbg_state;
  logic [15:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef LC3_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_c_grants, stat_l_grants, stat_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .o_dbg_state(o_dbg_state)
`ifdef LC3_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_c_grants(stat_c_grants),
    .stat_l_grants(stat_l_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Synchronous-read memory model
  logic [15:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0003] = 16'hABCD;
    mem[16'h0010] = 16'h5555;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        c_req, c_we;
    logic [15:0] c_addr, c_wdata;
    logic        l_req, l_we, l_lock;
    logic [15:0] l_addr, l_wdata;
    logic        e_c_gnt, e_l_gnt, e_we;
    logic [15:0] e_addr, e_wdata;
    logic        e_crv;
    logic [15:0] e_crd;
    logic        e_lrv;
    logic [15:0] e_lrd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                         input logic lr, input logic lw, input logic lk, input logic [15:0] la,
                         input logic [15:0] ld, input logic ecg, input logic elg, input logic ewe,
                         input logic [15:0] ea, input logic [15:0] ed, input logic ecrv,
                         input logic [15:0] ecrd, input logic elrv, input logic [15:0] elrd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.l_req = lr; v.l_we = lw; v.l_lock = lk; v.l_addr = la; v.l_wdata = ld;
    v.e_c_gnt = ecg; v.e_l_gnt = elg; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ed;
    v.e_crv = ecrv; v.e_crd = ecrd; v.e_lrv = elrv; v.e_lrd = elrd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
  endtask

  initial begin
    logic [15:0] n;
    logic        exp_l;
    logic        exp_lk;
    logic [15:0] exp_a;

    // Reset with c_req asserted: no grant may leak out
    reset = 1'b1;
    drive_idle();
    c_req = 1'b1; c_addr = 16'h0003;
`ifdef LC3_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #3;
    check("reset_state", {c_gnt, l_gnt, c_rvalid, l_rvalid, mem_we, mem_addr, mem_wdata, o_dbg_state},
          80'd0);
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;

    // Vector table: one entry per cycle
    add_vec(1,0,16'h0003,0,      0,0,0,0,0,              1,0,0,16'h0003,0,           0,0,          0,0);
    add_vec(0,0,0,0,             0,0,0,0,0,              0,0,0,0,0,                  1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           0,0,          0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       0,1,0,16'h0010,0,           1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           0,0,          1,16'h5555);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       1,0,0,16'h0003,0,           1,16'hABCD,   0,0);
    add_vec(1,0,16'h0003,0,      1,0,0,16'h0010,0,       0,1,0,16'h0010,0,           1,16'hABCD,   0,0);
    add_vec(0,0,0,0,             0,0,0,0,0,              0,0,0,0,0,                  0,0,          1,16'h5555);
    add_vec(1,1,16'h0010,16'h1234, 0,0,0,0,0,            1,0,1,16'h0010,16'h1234,    0,0,          0,0);
    add_vec(0,0,0,0,             1,0,0,16'h0010,0,       0,1,0,16'h0010,0,           0,0,          0,0);
    add_vec(0,0,0,0,             0,0,0,0,0,              0,0,0,0,0,                  0,0,          1,16'h1234);
    add_vec(0,0,0,0,             1,1,1,16'h2000,16'hA000, 0,1,1,16'h2000,16'hA000,   0,0,          0,0);
    add_vec(1,0,16'h0003,0,      1,1,1,16'h2001,16'hA001, 0,1,1,16'h2001,16'hA001,   0,0,          0,0);
    add_vec(1,0,16'h0003,0,      1,1,1,16'h2002,16'hA002, 0,1,1,16'h2002,16'hA002,   0,0,          0,0);
    add_vec(1,0,16'h0003,0,      1,1,0,16'h2003,16'hA003, 1,0,0,16'h0003,0,          0,0,          0,0);
    add_vec(0,0,0,0,             1,1,0,16'h2003,16'hA003, 0,1,1,16'h2003,16'hA003,   1,16'hABCD,   0,0);
    add_vec(0,0,0,0,             0,0,0,0,0,              0,0,0,0,0,                  0,0,          0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      c_req = vecs[i].c_req; c_we = vecs[i].c_we; c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
      l_req = vecs[i].l_req; l_we = vecs[i].l_we; l_lock = vecs[i].l_lock;
      l_addr = vecs[i].l_addr; l_wdata = vecs[i].l_wdata;
      #1;
      check($sformatf("vec%0d", i),
            {c_gnt, l_gnt, mem_we, mem_addr, mem_wdata, c_rvalid, c_rdata, l_rvalid, l_rdata},
            {vecs[i].e_c_gnt, vecs[i].e_l_gnt, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
             vecs[i].e_crv, vecs[i].e_crd, vecs[i].e_lrv, vecs[i].e_lrd});
    end

    // Locked write burst against a continuous core request: 4 C, 8 locked L, yield C, 3 C, relock L
    n = 16'd0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      c_req = 1; c_we = 0; c_addr = 16'h0003; c_wdata = 0;
      l_req = 1; l_we = 1; l_lock = 1; l_addr = 16'h3000 + n; l_wdata = 16'hB000 + n;
      exp_l  = (k >= 4 && k < 12) || (k == 16);
      exp_lk = (k >= 5 && k <= 11);
      exp_a  = exp_l ? (16'h3000 + n) : 16'h0003;
      #1;
      check($sformatf("burst%0d", k), {c_gnt, l_gnt, mem_we, mem_addr, o_dbg_state},
            {!exp_l, exp_l, exp_l, exp_a, exp_lk});
      if (exp_l) n = n + 16'd1;
    end

    // Locked read in flight, then reset mid-cycle
    @(negedge clk);
    l_we = 0; l_addr = 16'h0003; l_wdata = 0;
    #1;
    check("lock_read_gnt", {c_gnt, l_gnt, mem_we, mem_addr, o_dbg_state}, {1'b0, 1'b1, 1'b0, 16'h0003, 1'b1});
    @(posedge clk);
    #1;
    check("lock_read_rv", {l_rvalid, l_rdata, c_rvalid}, {1'b1, 16'hABCD, 1'b0});
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid", {c_gnt, l_gnt, c_rvalid, l_rvalid, l_rdata, mem_we, mem_addr, mem_wdata, o_dbg_state},
          80'd0);
    @(negedge clk);
    reset = 1'b0;
    c_req = 1; c_we = 0; c_addr = 16'h0003;
    l_req = 1; l_we = 0; l_lock = 1; l_addr = 16'h3009;
    #1;
    check("post_reset_gnt", {c_gnt, l_gnt, mem_we, mem_addr}, {1'b1, 1'b0, 1'b0, 16'h0003});
    @(negedge clk);
    drive_idle();
    #1;
    check("post_reset_rv", {c_rvalid, c_rdata, l_rvalid}, {1'b1, 16'hABCD, 1'b0});

`ifdef LC3_ARB_STATS_EN
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      c_req = 1; c_addr = 16'h0003; l_req = 1; l_we = 0; l_lock = 0; l_addr = 16'h0010;
      @(negedge clk);
    end
    drive_idle();
    #1;
    check("stat_conflicts", {64'd0, stat_conflicts}, {64'd0, 16'd10});
    check("stat_grant_sum", {64'd0, stat_c_grants + stat_l_grants}, {64'd0, 16'd10});
    @(negedge clk);
    c_req = 1; c_addr = 16'h0003; stat_clr = 1'b1;
    @(negedge clk);
    drive_idle();
    stat_clr = 1'b0;
    #1;
    check("stat_clr", {32'd0, stat_c_grants, stat_l_grants, stat_conflicts}, 80'd0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares the single synchronous-read 16-bit program/data memory between two requesters: the LC3 core (requester C) and the program loader/debug port (requester L).
- Sits between both requesters and the memory array, and drives the memory address, write data and write enable.
- Uses fixed priority with C ahead of L, plus a starvation guard for L.
- L may lock the memory for a bounded burst. C observes a denial through c_gnt=0 and holds its request.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory.
- DATA_W, 16, data width.
- STARVE_LIM, 4, number of consecutive denied L-request cycles after which L wins the next arbitration. Legal range 1..15.
- BURST_MAX, 8, maximum consecutive locked L grants. Legal range 1..255.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- c_req  in  1  core access request.
- c_we  in  1  core write (1) or read (0).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  core access performed this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- l_req  in  1  loader access request.
- l_we  in  1  loader write (1) or read (0).
- l_lock  in  1  loader requests burst ownership.
- l_addr  in  ADDR_W  loader address.
- l_wdata  in  DATA_W  loader write data.
- l_gnt  out  1  loader access performed this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DATA_W  loader read data.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address is presented.

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - state=ARB, starve_cnt=0, burst_cnt=0, yield=0.
  - c_gnt=0, l_gnt=0, c_rvalid=0, l_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Grants are combinational from the current request inputs and registered state. At most one grant is asserted per cycle.
- A granted access completes in the same cycle.
- The requester holds req, we, addr and wdata stable until it sees its gnt=1.
- Memory mux:
  - Grant to C: mem_addr=c_addr, mem_wdata=c_wdata, mem_we=c_we.
  - Grant to L: mem_addr=l_addr, mem_wdata=l_wdata, mem_we=l_we.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - x_rvalid is registered: it is 1 the cycle after x_gnt=1 with x_we=0, and 0 otherwise.
  - x_rdata=mem_rdata when x_rvalid=1, 0 otherwise.
  - Read latency is 1 cycle after the grant.
- State ARB arbitration, in this order:
  - yield=1 and c_req: grant C.
  - starve_cnt==STARVE_LIM and l_req: grant L.
  - c_req: grant C.
  - l_req: grant L.
- starve_cnt:
  - +1 on each cycle with l_req=1 and l_gnt=0; saturates at STARVE_LIM.
  - Cleared on any l_gnt, or when l_req=0.
- Entering LOCK: in ARB, an L grant with l_lock=1 moves to state LOCK and sets burst_cnt=1.
- State LOCK:
  - L is granted whenever l_req=1. C is denied regardless of c_req.
  - burst_cnt increments on each L grant.
  - LOCK->ARB when l_lock=0 or l_req=0. That cycle is evaluated with ARB rules, i.e. no dead cycle.
  - LOCK->ARB with yield=1 when burst_cnt==BURST_MAX. The grant that reaches BURST_MAX is the last locked grant.
- yield clears after one ARB cycle, whether or not C used it.
- Reset mid-burst returns to ARB immediately. In-flight rvalid is dropped.
- Simultaneous c_req and l_req in ARB with starve_cnt<STARVE_LIM and yield=0: C wins.

Optional Feature:
- Macro: LC3_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_c_grants[15:0], stat_l_grants[15:0] and stat_conflicts[15:0].
  - The grant counters count grants to each requester; the conflict counter counts cycles with c_req & l_req.
  - All three wrap at 16'hFFFF->0 and reset to 0.
  - Adds input stat_clr, a synchronous clear that takes precedence over an increment in the same cycle.
- Undefined: no such ports and no counter logic. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset asserted mid-cycle with c_req=1 -> all gnt, rvalid and mem_we are 0 immediately. After release, the first c_req read of addr 16'h0003 gives c_gnt=1 and mem_addr=16'h0003, then c_rvalid=1 with c_rdata equal to the memory content.
- c_req and l_req held continuously, STARVE_LIM=4, l_lock=0 -> C is granted 4 cycles, L on cycle 5 (starve_cnt=4), then C again. Pattern repeats every 5 cycles.
- L write burst with l_lock=1, BURST_MAX=8, c_req=1 throughout -> 8 consecutive l_gnt with mem_we=1 at addrs 16'h3000..16'h3007. Next cycle c_gnt=1 (yield), then L is granted again only via ARB rules.
- L locked burst of 3 then l_lock=0 while c_req=1 -> the cycle after the 3rd L grant gives c_gnt=1 with no idle cycle. burst_cnt does not reach BURST_MAX.
- C write of 16'h1234 to 16'h0010, then L read of 16'h0010 -> l_rvalid=1 one cycle after l_gnt, l_rdata=16'h1234. c_rvalid stays 0.
- LC3_ARB_STATS_EN: 10 cycles of dual requests -> stat_conflicts=10 and stat_c_grants+stat_l_grants=10. Asserting stat_clr together with a grant gives all counters 0 the next cycle.
